// File: rtl/knn_mem_arbiter.sv
// Round-robin arbiter sharing one on-chip memory port between the KNN controller (0)
// and the host loader (1); owns strobe timing and the fixed read latency.
module knn_mem_arbiter #(
    parameter int W      = 32,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [W-1:0]      wdata0,
    input  logic              lock0,
    output logic              ack0,
    output logic [W-1:0]      rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [W-1:0]      wdata1,
    input  logic              lock1,
    output logic              ack1,
    output logic [W-1:0]      rdata1,
    output logic              read,
    output logic [ADDR_W-1:0] readaddress,
    input  logic [W-1:0]      readdata,
    output logic              write,
    output logic [ADDR_W-1:0] writeaddress,
    output logic [W-1:0]      writedata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        ack_q, ack_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic              lock_q, lock_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [W-1:0]      wdout_q, wdout_d;

    logic [1:0]        req_v;
    logic              lock_hold;
    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [W-1:0]      win_wdata;
    logic              sample_rd;

    assign req_v     = {req1, req0};
    assign sample_rd = (state_q == S_WAIT) && (cnt_q == 4'd1);

    // A lock only survives while its owner keeps requesting.
    always_comb begin
        lock_hold = lock_q & req_v[last_q];
        if (req_v == 2'b11) begin
            win = lock_hold ? last_q : ~last_q;
        end else begin
            win = req_v[1];
        end
        win_we    = win ? we1 : we0;
        win_addr  = win ? addr1 : addr0;
        win_wdata = win ? wdata1 : wdata0;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = 2'b00;
        we_d    = we_q;
        last_d  = last_q;
        lock_d  = lock_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdout_d = wdout_q;
        case (state_q)
            S_IDLE: begin
                lock_d = lock_hold;
                if (req_v != 2'b00) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    we_d    = win_we;
                    last_d  = win;
                    state_d = S_ISSUE;
                    // Strobes are registered here so they are high during ISSUE.
                    if (win_we) begin
                        write_d = 1'b1;
                        waddr_d = win_addr;
                        wdout_d = win_wdata;
                    end else begin
                        read_d  = 1'b1;
                        raddr_d = win_addr;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    ack_d   = grant_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = 4'(RD_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    ack_d   = grant_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                lock_d  = grant_q[1] ? lock1 : lock0;
                state_d = S_GAP;
            end
            S_GAP: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            ack_q   <= 2'b00;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
            lock_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            cnt_q   <= 4'd0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdout_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            read_q  <= read_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdout_q <= wdout_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            logic [W-1:0] rdata_q, rdata_d;
            always_comb begin
                rdata_d = (sample_rd && grant_q[gi]) ? readdata : rdata_q;
            end
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end
            if (gi == 0) begin : g_out0
                assign rdata0 = rdata_q;
            end else begin : g_out1
                assign rdata1 = rdata_q;
            end
        end
    endgenerate

    // Gating with reset drops strobes and acks in the very first reset cycle.
    assign read         = read_q & rst;
    assign write        = write_q & rst;
    assign ack0         = ack_q[0] & rst;
    assign ack1         = ack_q[1] & rst;
    assign readaddress  = raddr_q;
    assign writeaddress = waddr_q;
    assign writedata    = wdout_q;
    assign grant        = grant_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_knn_mem_arbiter.sv
// Bench for knn_mem_arbiter: transaction-level timing model checked every cycle,
// directed scenarios with literal expectations, and an RD_LAT=1/5 latency sweep.
module tb_knn_mem_arbiter;

    localparam int W   = 32;
    localparam int AW  = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]    req, we, lock;
    logic [AW-1:0] addr [2];
    logic [W-1:0]  wdata [2];
    wire  [1:0]    ack;
    wire  [W-1:0]  rdata [2];
    wire           rd, wr, busy;
    wire  [AW-1:0] raddr, waddr;
    wire  [W-1:0]  wdout;
    wire  [1:0]    grant;
    logic [W-1:0]  readdata;

    knn_mem_arbiter #(.W(W), .ADDR_W(AW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .lock0(lock[0]),
        .ack0(ack[0]), .rdata0(rdata[0]),
        .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .lock1(lock[1]),
        .ack1(ack[1]), .rdata1(rdata[1]),
        .read(rd), .readaddress(raddr), .readdata(readdata),
        .write(wr), .writeaddress(waddr), .writedata(wdout),
        .grant(grant), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Memory: readdata is only meaningful exactly LAT cycles after the strobe.
    logic [W-1:0]  mem [0:65535];
    int            rd_target = -1;
    logic [AW-1:0] rd_a = '0;
    int            rd_strobe_cyc = -1, wr_strobe_cyc = -1, rd_cnt = 0, ack0_cnt = 0;

    always @(negedge clk) begin
        if (rd) begin
            rd_target     = cyc + LAT;
            rd_a          = raddr;
            rd_strobe_cyc = cyc;
            rd_cnt++;
        end
        if (wr) begin
            mem[waddr]    = wdout;
            wr_strobe_cyc = cyc;
        end
        if (ack[0]) ack0_cnt++;
    end

    always @(posedge clk) begin
        #1;
        readdata = (cyc == rd_target) ? mem[rd_a] : (32'h5A5A0000 ^ 32'(cyc));
    end

    // Transaction model: one access at a time, timed from its arbitration cycle.
    int            m_active = 0, m_t = 0, m_own = 0, m_lat = 0, m_ptr = 1, m_w = 0;
    logic          m_we = 1'b0, m_lock = 1'b0;
    logic [AW-1:0] m_addr = '0, e_raddr = '0, e_waddr = '0;
    logic [W-1:0]  m_wd = '0, e_wdata = '0;
    logic [W-1:0]  e_rdata [2];
    logic [1:0]    e_grant, e_ack;
    logic          e_read, e_write, in_acc;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_strobes", 64'({rd, wr, ack}), 64'(0));
            m_active = 0; m_ptr = 1; m_lock = 1'b0;
            e_raddr = '0; e_waddr = '0; e_wdata = '0;
            e_rdata[0] = '0; e_rdata[1] = '0;
        end else begin
            if (m_active != 0 && cyc == m_t + 1) begin
                if (m_we) begin e_waddr = m_addr; e_wdata = m_wd; end
                else e_raddr = m_addr;
            end
            if (m_active != 0 && !m_we && cyc == m_t + 2 + m_lat) e_rdata[m_own] = mem[m_addr];
            in_acc  = (m_active != 0) && cyc >= m_t + 1 && cyc <= m_t + 3 + m_lat;
            e_grant = in_acc ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_read  = (m_active != 0) && !m_we && cyc == m_t + 1;
            e_write = (m_active != 0) && m_we && cyc == m_t + 1;
            e_ack   = ((m_active != 0) && cyc == m_t + 2 + m_lat) ? e_grant : 2'b00;
            chk("grant", 64'(grant), 64'(e_grant));
            chk("busy", 64'(busy), 64'(in_acc));
            chk("read", 64'(rd), 64'(e_read));
            chk("write", 64'(wr), 64'(e_write));
            chk("ack", 64'(ack), 64'(e_ack));
            chk("readaddress", 64'(raddr), 64'(e_raddr));
            chk("writeaddress", 64'(waddr), 64'(e_waddr));
            chk("writedata", 64'(wdout), 64'(e_wdata));
            chk("rdata0", 64'(rdata[0]), 64'(e_rdata[0]));
            chk("rdata1", 64'(rdata[1]), 64'(e_rdata[1]));
            if (m_active == 0) begin
                if (m_lock && !req[m_ptr]) m_lock = 1'b0;
                if (req != 2'b00) begin
                    if (req == 2'b11) m_w = m_lock ? m_ptr : 1 - m_ptr;
                    else m_w = req[1] ? 1 : 0;
                    m_active = 1; m_t = cyc; m_own = m_w; m_ptr = m_w;
                    m_we = we[m_w]; m_addr = addr[m_w]; m_wd = wdata[m_w];
                    m_lat = m_we ? 0 : LAT;
                end
            end else begin
                if (cyc == m_t + 2 + m_lat) m_lock = lock[m_own];
                if (cyc == m_t + 3 + m_lat) m_active = 0;
            end
        end
    end

    // Sweep instances with RD_LAT 1 and 5, read-only on requester 0.
    logic [1:0]    s_req;
    wire  [1:0]    s_ack, s_rd, s_ack1, s_wr, s_busy;
    wire  [W-1:0]  s_rdata [2];
    wire  [W-1:0]  s_rdata1 [2];
    wire  [W-1:0]  s_wdout [2];
    wire  [AW-1:0] s_raddr [2];
    wire  [AW-1:0] s_waddr [2];
    wire  [1:0]    s_grant [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sweep
            localparam int SL = (gi == 0) ? 1 : 5;
            int           tgt = -1;
            int           rdc = -1;
            logic [W-1:0] rdd = '0;
            knn_mem_arbiter #(.W(W), .ADDR_W(AW), .RD_LAT(SL)) u_dut (
                .clk(clk), .rst(rst),
                .req0(s_req[gi]), .we0(1'b0), .addr0(16'(16 + gi)), .wdata0('0), .lock0(1'b0),
                .ack0(s_ack[gi]), .rdata0(s_rdata[gi]),
                .req1(1'b0), .we1(1'b0), .addr1('0), .wdata1('0), .lock1(1'b0),
                .ack1(s_ack1[gi]), .rdata1(s_rdata1[gi]),
                .read(s_rd[gi]), .readaddress(s_raddr[gi]), .readdata(rdd),
                .write(s_wr[gi]), .writeaddress(s_waddr[gi]), .writedata(s_wdout[gi]),
                .grant(s_grant[gi]), .busy(s_busy[gi])
            );
            always @(negedge clk) begin
                if (s_rd[gi]) begin tgt = cyc + SL; rdc = cyc; end
            end
            always @(posedge clk) begin
                #1;
                rdd = (cyc == tgt) ? (32'hC0DE0000 | 32'(s_raddr[gi])) : (32'hBAD00000 ^ 32'(cyc));
            end
        end
    endgenerate

    int order [$];
    int last_ack_cyc [2];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Requester: holds req for n accesses, bumping addr/data after each ack.
    task automatic serve(input int i, input int n, input logic w, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input logic drop_lock);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        for (int k = 0; k < n; k++) begin
            int bound = 0;
            while (!ack[i] && bound < 40) begin step(1); bound++; end
            if (!ack[i]) chk("ack_timeout", 64'(0), 64'(1));
            order.push_back(i);
            last_ack_cyc[i] = cyc;
            if (drop_lock && k == n - 1) lock[i] = 1'b0;
            addr[i]  = a + AW'(k + 1);
            wdata[i] = d + W'(k + 1);
            if (k == n - 1) req[i] = 1'b0;
            step(1);
        end
    endtask

    int t, a0, rc;
    int exp01 [4] = '{0, 1, 0, 1};
    int exp_lk [4] = '{0, 0, 0, 1};
    int s_ackc [2];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'(i) * 32'h9E3779B1;
        mem[16'h0040] = 32'hDEADBEEF;
        req = '0; we = '0; lock = '0; s_req = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        rst = 1'b0;
        step(3);
        @(negedge clk);
        chk("reset_grant", 64'(grant), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_rdata0", 64'(rdata[0]), 64'(0));
        chk("reset_raddr", 64'(raddr), 64'(0));
        step(1);
        rst = 1'b1;
        step(2);

        t = cyc;
        serve(0, 1, 1'b0, 16'h0040, '0, 1'b0);
        $display("read0 addr=0040 ack_at=t+%0d rdata0=%08h", last_ack_cyc[0] - t, rdata[0]);
        chk("rd_strobe_lat", 64'(rd_strobe_cyc - t), 64'(1));
        chk("rd_ack_lat", 64'(last_ack_cyc[0] - t), 64'(4));
        chk("rd_data", 64'(rdata[0]), 64'(32'hDEADBEEF));
        step(2);

        rc = rd_cnt;
        t = cyc;
        serve(1, 1, 1'b1, 16'h0100, 32'h3, 1'b0);
        $display("write1 addr=0100 data=3 ack_at=t+%0d", last_ack_cyc[1] - t);
        chk("wr_strobe_lat", 64'(wr_strobe_cyc - t), 64'(1));
        chk("wr_ack_lat", 64'(last_ack_cyc[1] - t), 64'(2));
        chk("wr_mem", 64'(mem[16'h0100]), 64'(3));
        chk("wr_no_read", 64'(rd_cnt), 64'(rc));
        step(2);

        order.delete();
        fork
            serve(0, 2, 1'b0, 16'h0200, '0, 1'b0);
            serve(1, 2, 1'b0, 16'h0300, '0, 1'b0);
        join
        chk("rr_count", 64'(order.size()), 64'(4));
        for (int k = 0; k < 4 && k < order.size(); k++) begin
            $display("contention access %0d granted %0d", k, order[k]);
            chk("rr_order", 64'(order[k]), 64'(exp01[k]));
        end
        step(2);

        order.delete();
        lock[0] = 1'b1;
        fork
            serve(0, 3, 1'b1, 16'h0400, 32'h1000, 1'b1);
            serve(1, 1, 1'b1, 16'h0500, 32'h2000, 1'b0);
        join
        chk("lock_count", 64'(order.size()), 64'(4));
        for (int k = 0; k < 4 && k < order.size(); k++) begin
            $display("lock burst access %0d granted %0d", k, order[k]);
            chk("lock_order", 64'(order[k]), 64'(exp_lk[k]));
        end
        chk("lock_mem", 64'(mem[16'h0402]), 64'(32'h1002));
        step(2);

        a0 = ack0_cnt;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0040;
        step(2);
        rst = 1'b0; req[0] = 1'b0;
        step(1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_read", 64'(rd), 64'(0));
        chk("rstmid_grant", 64'(grant), 64'(0));
        chk("rstmid_busy", 64'(busy), 64'(0));
        chk("rstmid_rdata0", 64'(rdata[0]), 64'(0));
        step(8);
        chk("rstmid_no_ack", 64'(ack0_cnt), 64'(a0));
        $display("reset mid-read abandoned, ack0 pulses=%0d", ack0_cnt - a0);
        t = cyc;
        serve(0, 1, 1'b0, 16'h0040, '0, 1'b0);
        chk("rstmid_rd_lat", 64'(last_ack_cyc[0] - t), 64'(4));
        chk("rstmid_rd_data", 64'(rdata[0]), 64'(32'hDEADBEEF));
        step(2);

        s_ackc[0] = -1; s_ackc[1] = -1;
        s_req = 2'b11;
        t = cyc;
        for (int n = 0; n < 30 && (s_ackc[0] < 0 || s_ackc[1] < 0); n++) begin
            step(1);
            for (int k = 0; k < 2; k++) begin
                if (s_ack[k] && s_ackc[k] < 0) begin s_ackc[k] = cyc; s_req[k] = 1'b0; end
            end
        end
        $display("sweep RD_LAT=1 ack_at=t+%0d data=%08h", s_ackc[0] - t, s_rdata[0]);
        $display("sweep RD_LAT=5 ack_at=t+%0d data=%08h", s_ackc[1] - t, s_rdata[1]);
        chk("sw1_strobe", 64'(g_sweep[0].rdc - t), 64'(1));
        chk("sw5_strobe", 64'(g_sweep[1].rdc - t), 64'(1));
        chk("sw1_ack", 64'(s_ackc[0] - t), 64'(3));
        chk("sw5_ack", 64'(s_ackc[1] - t), 64'(7));
        chk("sw1_data", 64'(s_rdata[0]), 64'(32'hC0DE0010));
        chk("sw5_data", 64'(s_rdata[1]), 64'(32'hC0DE0011));
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_mem_arbiter.md
Name: knn_mem_arbiter

Overview:
- Shares the single on-chip memory port (read/readaddress/readdata, write/writeaddress/writedata) between two requesters.
- Requester 0 is the KNN memory controller, which fetches training/input vectors and writes inferred types back. Requester 1 is the host loader/readback engine.
- Arbitration is round-robin, with an optional lock for back-to-back bursts. The block sits between the requesters and the memory and owns all memory timing, including fixed read latency.

Parameters:
- W, 32, data word width.
- ADDR_W, 16, memory address width.
- RD_LAT, 2, cycles from the read-high cycle to valid readdata; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the next clk edge).
- req0  in  1  requester 0 access request; level, held until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read; stable while req0.
- addr0  in  ADDR_W  requester 0 address; stable while req0.
- wdata0  in  W  requester 0 write data; stable while req0.
- lock0  in  1  requester 0: keep the grant for the next access.
- ack0  out  1  one-cycle completion pulse to requester 0.
- rdata0  out  W  read data for requester 0; valid while ack0 is high, held afterwards.
- req1, we1, addr1, wdata1, lock1, ack1, rdata1: same meanings for requester 1.
- read  out  1  memory read strobe.
- readaddress  out  ADDR_W  memory read address.
- readdata  in  W  memory read data.
- write  out  1  memory write strobe.
- writeaddress  out  ADDR_W  memory write address.
- writedata  out  W  memory write data.
- grant  out  2  one-hot owner of the current access; 00 when idle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - read, write, ack0, ack1 = 0.
  - readaddress, writeaddress, writedata, rdata0, rdata1 = 0.
  - grant = 00, busy = 0.
  - Internal last-served pointer = 1, so requester 0 wins the first tie. Lock flag = 0. Wait counter = 0. State = IDLE.
- Reset mid-operation: the access is abandoned. Strobes and acks are low from the first reset cycle, and no ack is issued for the abandoned access.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - No request: stay in IDLE.
  - Only one reqN high: grant it.
  - Both high:
    - Lock flag set: the locked owner wins.
    - Otherwise: the requester that is not the last-served pointer wins.
  - Register grant, we, addr and wdata of the winner. Update the pointer to the winner. Go to ISSUE.
- ISSUE (one cycle):
  - Read: read=1, readaddress=latched addr. Counter loaded with RD_LAT. Next state WAIT.
  - Write: write=1, writeaddress=latched addr, writedata=latched wdata. Next state RESP.
  - Strobes are high for exactly one cycle. readaddress, writeaddress and writedata hold their values after the strobe.
- WAIT:
  - read=0. The counter decrements each cycle.
  - In the cycle the counter equals 1, readdata is sampled into the granted rdataN; the other rdata is unchanged. Next state RESP.
  - WAIT therefore lasts RD_LAT cycles, and readdata is sampled exactly RD_LAT cycles after the read-high cycle.
- RESP (one cycle):
  - ackN=1 for the granted requester only.
  - Lock flag is set to lockN sampled in this cycle. Next state GAP.
- GAP (one cycle):
  - No strobes, no ack, grant still held. Next state IDLE.
  - Lets a registered requester drop req before the next arbitration, so a completed request is never re-served.
- Latency, with req visible at IDLE cycle t:
  - Read: strobe at t+1, ack at t+2+RD_LAT, next arbitration at t+4+RD_LAT.
  - Write: strobe at t+1, ack at t+2, next arbitration at t+4.
- Lock rules:
  - With lock set, a locked owner whose req is high in IDLE wins even against the round-robin pointer.
  - If the locked owner's req is low in IDLE, the lock flag clears and normal arbitration applies in that same cycle.
- Request inputs are ignored outside IDLE. Changing addr, we or wdata mid-access has no effect.
- read and write are never high in the same cycle. At most one ack is high per cycle.

Test Plan:
- Single read, RD_LAT=2: req0=1, we0=0, addr0=0x0040, memory returns 0xDEADBEEF. Required: read=1 with readaddress=0x0040 exactly at t+1; readdata sampled at t+3; ack0 at t+4 with rdata0=0xDEADBEEF; grant=01 from t+1; busy low again at t+6.
- Single write: req1=1, we1=1, addr1=0x0100, wdata1=0x00000003. Required: write=1 for one cycle at t+1 with writeaddress=0x0100 and writedata=3; ack1 at t+2; read never asserted.
- Contention: req0 and req1 both held high continuously, lock=0. Required: grants alternate 0,1,0,1 across four accesses, and each ack goes only to the granted requester.
- Lock burst: req0/req1 both high, lock0=1 for 3 accesses, then lock0=0. Required: requester 0 gets 3 consecutive grants, and the next grant goes to requester 1.
- Reset mid-read: rst=0 in the first WAIT cycle. Required: the next edge gives read=0, grant=00 and busy=0; no ack0 pulse for the abandoned read; after release, a fresh req0 read completes normally.
- Parameter sweep RD_LAT=1 and RD_LAT=5: single read. Required: ack at t+3 and t+7 respectively, with readdata sampled exactly RD_LAT cycles after the read strobe.
